// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection; 1-cycle ID->EX latency, bubbles on flush/load-use, holds on stall_ext.
// Optional bubble counter output enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_ext,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [4:0]         id_RS_1,
  input  logic [4:0]         id_RS_2,
  input  logic [4:0]         id_rd,
  input  logic               id_regWrite,
  input  logic               id_memRead,
  input  logic               id_memWrite,
  input  logic               id_memToReg,
  input  logic               id_aluSrc,
  input  logic [ALUOP_W-1:0] id_aluOp,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [XLEN-1:0]    ex_imm,
  output logic [4:0]         ex_RS_1,
  output logic [4:0]         ex_RS_2,
  output logic [4:0]         ex_rd,
  output logic               ex_regWrite,
  output logic               ex_memRead,
  output logic               ex_memWrite,
  output logic               ex_memToReg,
  output logic               ex_aluSrc,
  output logic [ALUOP_W-1:0] ex_aluOp,
  output logic               load_use_stall,
  output logic               pc_write,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]        bubble_count,
`endif
  output logic               ifid_write
);

  logic bubble;

  // Built only from EX registers and ID indices so flush/stall_ext never feed back into it.
  assign load_use_stall = ex_valid & ex_memRead & (ex_rd != 5'd0) & id_valid &
                          ((ex_rd == id_RS_1) | (ex_rd == id_RS_2));
  assign pc_write   = ~(load_use_stall | stall_ext);
  assign ifid_write = ~(load_use_stall | stall_ext);
  assign bubble     = ~stall_ext & (flush | load_use_stall);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_RS_1     <= '0;
      ex_RS_2     <= '0;
      ex_rd       <= '0;
      ex_regWrite <= 1'b0;
      ex_memRead  <= 1'b0;
      ex_memWrite <= 1'b0;
      ex_memToReg <= 1'b0;
      ex_aluSrc   <= 1'b0;
      ex_aluOp    <= '0;
    end else if (stall_ext) begin
      // hold every register
    end else if (bubble) begin
      // Data and index fields keep their old values; only control is squashed.
      ex_valid    <= 1'b0;
      ex_regWrite <= 1'b0;
      ex_memRead  <= 1'b0;
      ex_memWrite <= 1'b0;
      ex_memToReg <= 1'b0;
      ex_aluSrc   <= 1'b0;
      ex_aluOp    <= '0;
    end else begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_RS_1     <= id_RS_1;
      ex_RS_2     <= id_RS_2;
      ex_rd       <= id_rd;
      ex_regWrite <= id_regWrite & id_valid;
      ex_memRead  <= id_memRead  & id_valid;
      ex_memWrite <= id_memWrite & id_valid;
      ex_memToReg <= id_memToReg & id_valid;
      ex_aluSrc   <= id_aluSrc   & id_valid;
      ex_aluOp    <= id_valid ? id_aluOp : '0;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)         bubble_count <= '0;
    else if (bubble) bubble_count <= bubble_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized self-checking bench for id_ex_stage against a transaction-level stage model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1, rs2, imm;
    logic [4:0]  rs_1, rs_2, rd;
    logic        rw, mr, mw, m2r, asrc;
    logic [3:0]  aluop;
  } stage_t;

  logic   clk = 1'b0;
  logic   rst, stall_ext, flush;
  stage_t idin, obs, exp_st;
  logic   ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_RS_1, ex_RS_2, ex_rd;
  logic [3:0]  ex_aluOp;
  logic        load_use_stall, pc_write, ifid_write;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_count;
`endif
  int unsigned model_bubbles;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .ALUOP_W(4)) dut (
    .clk(clk), .rst(rst), .stall_ext(stall_ext), .flush(flush),
    .id_valid(idin.valid), .id_pc(idin.pc), .id_rs1_data(idin.rs1), .id_rs2_data(idin.rs2),
    .id_imm(idin.imm), .id_RS_1(idin.rs_1), .id_RS_2(idin.rs_2), .id_rd(idin.rd),
    .id_regWrite(idin.rw), .id_memRead(idin.mr), .id_memWrite(idin.mw),
    .id_memToReg(idin.m2r), .id_aluSrc(idin.asrc), .id_aluOp(idin.aluop),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_RS_1(ex_RS_1), .ex_RS_2(ex_RS_2), .ex_rd(ex_rd),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_memToReg(ex_memToReg), .ex_aluSrc(ex_aluSrc), .ex_aluOp(ex_aluOp),
    .load_use_stall(load_use_stall), .pc_write(pc_write),
`ifdef ID_EX_PERF_CNT_EN
    .bubble_count(bubble_count),
`endif
    .ifid_write(ifid_write)
  );

  assign obs = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_RS_1, ex_RS_2, ex_rd,
                ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, ex_aluOp};

  // A load in EX blocks a valid ID instruction reading its (non-x0) destination.
  function automatic bit hazard(stage_t e, stage_t i);
    return e.valid && e.mr && e.rd != 0 && i.valid && (e.rd == i.rs_1 || e.rd == i.rs_2);
  endfunction

  function automatic stage_t rand_id(int max_idx);
    stage_t r;
    r.valid = 1'($urandom_range(0, 3) != 0);
    r.pc = $urandom; r.rs1 = $urandom; r.rs2 = $urandom; r.imm = $urandom;
    r.rs_1 = 5'($urandom_range(0, max_idx));
    r.rs_2 = 5'($urandom_range(0, max_idx));
    r.rd   = 5'($urandom_range(0, max_idx));
    r.rw = 1'($urandom); r.mr = 1'($urandom); r.mw = 1'($urandom);
    r.m2r = 1'($urandom); r.asrc = 1'($urandom); r.aluop = 4'($urandom);
    return r;
  endfunction

  // One clock edge: advance the reference model, then return 1 time unit after the edge.
  task automatic step();
    bit haz;
    haz = hazard(exp_st, idin);
    @(posedge clk);
    if (rst) begin
      exp_st = '0;
      model_bubbles = 0;
    end else if (!stall_ext) begin
      if (flush || haz) begin
        exp_st.valid = 0; exp_st.rw = 0; exp_st.mr = 0; exp_st.mw = 0;
        exp_st.m2r = 0; exp_st.asrc = 0; exp_st.aluop = 0;
        model_bubbles++;
      end else begin
        exp_st = idin;
        if (!idin.valid) begin
          exp_st.rw = 0; exp_st.mr = 0; exp_st.mw = 0;
          exp_st.m2r = 0; exp_st.asrc = 0; exp_st.aluop = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; stall_ext = 0; flush = 0; idin = '1;
    exp_st = '0; model_bubbles = 0;
    step(); step();
    checks++;
    if (obs !== 0) begin errors++; $display("FAIL reset_outputs: got %h want 0", obs); end
    checks++;
    if (pc_write !== 1'b1 || ifid_write !== 1'b1 || load_use_stall !== 1'b0) begin
      errors++; $display("FAIL reset_enables: got pc_write=%b ifid_write=%b lus=%b want 1 1 0",
                          pc_write, ifid_write, load_use_stall);
    end
    rst = 0;
  endtask

  task automatic test_plain_flow();
    idin = rand_id(31); idin.valid = 1; idin.rd = 5; idin.rw = 1; idin.pc = 32'h100; idin.mr = 0;
    step();
    checks++;
    if (ex_rd !== 5'd5 || ex_regWrite !== 1'b1 || ex_pc !== 32'h100 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL plain_flow: got rd=%0d rw=%b pc=%h valid=%b want 5 1 100 1",
                          ex_rd, ex_regWrite, ex_pc, ex_valid);
    end
    checks++;
    if (obs !== exp_st) begin errors++; $display("FAIL plain_fields: got %h want %h", obs, exp_st); end
    idin.valid = 0; idin.rw = 1; idin.mw = 1; idin.aluop = 4'hF;
    step();
    checks++;
    if (obs !== exp_st || ex_regWrite !== 1'b0 || ex_aluOp !== 4'h0) begin
      errors++; $display("FAIL invalid_load: got %h want %h", obs, exp_st);
    end
  endtask

  task automatic test_load_use();
    idin = rand_id(31); idin.valid = 1; idin.mr = 1; idin.rd = 3;
    step();
    idin = rand_id(31); idin.valid = 1; idin.mr = 0; idin.rs_1 = 7; idin.rs_2 = 3;
    #1;
    checks++;
    if (load_use_stall !== 1'b1 || pc_write !== 1'b0 || ifid_write !== 1'b0) begin
      errors++; $display("FAIL load_use_detect: got lus=%b pc_write=%b ifid_write=%b want 1 0 0",
                          load_use_stall, pc_write, ifid_write);
    end
    step();
    checks++;
    if (ex_valid !== 1'b0 || ex_memRead !== 1'b0 || obs !== exp_st) begin
      errors++; $display("FAIL load_use_bubble: got %h want %h", obs, exp_st);
    end
    checks++;
    if (load_use_stall !== 1'b0 || pc_write !== 1'b1) begin
      errors++; $display("FAIL load_use_release: got lus=%b pc_write=%b want 0 1", load_use_stall, pc_write);
    end
    step();
    checks++;
    if (ex_RS_2 !== 5'd3 || ex_valid !== 1'b1 || obs !== exp_st) begin
      errors++; $display("FAIL load_use_replay: got RS_2=%0d valid=%b want 3 1", ex_RS_2, ex_valid);
    end
  endtask

  task automatic test_x0_dest();
    idin = rand_id(31); idin.valid = 1; idin.mr = 1; idin.rd = 0;
    step();
    idin = rand_id(31); idin.valid = 1; idin.rs_1 = 0; idin.rs_2 = 0;
    #1;
    checks++;
    if (load_use_stall !== 1'b0) begin
      errors++; $display("FAIL x0_no_stall: got lus=%b want 0", load_use_stall);
    end
    step();
    checks++;
    if (ex_valid !== 1'b1 || obs !== exp_st) begin
      errors++; $display("FAIL x0_no_bubble: got %h want %h", obs, exp_st);
    end
  endtask

  task automatic test_flush_stall();
    stage_t held;
    idin = rand_id(31); idin.valid = 1; idin.rw = 1; idin.mr = 0;
    step();
    idin = rand_id(31); idin.valid = 1; idin.rw = 1;
    flush = 1;
    step();
    checks++;
    if (ex_regWrite !== 1'b0 || ex_valid !== 1'b0 || obs !== exp_st) begin
      errors++; $display("FAIL flush_bubble: got %h want %h", obs, exp_st);
    end
    flush = 0;
    idin = rand_id(31); idin.valid = 1; idin.rw = 1; idin.mr = 1; idin.rd = 9;
    step();
    held = exp_st;
    idin = rand_id(31); idin.valid = 1; idin.rs_1 = 9;
    flush = 1; stall_ext = 1;
    #1;
    checks++;
    if (load_use_stall !== 1'b1 || pc_write !== 1'b0) begin
      errors++; $display("FAIL stall_hazard_flag: got lus=%b pc_write=%b want 1 0", load_use_stall, pc_write);
    end
    step();
    checks++;
    if (obs !== held) begin errors++; $display("FAIL flush_under_stall: got %h want %h", obs, held); end
    flush = 0; stall_ext = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idin = rand_id(3);
      rst = 1'($urandom_range(0, 49) == 0);
      stall_ext = 1'($urandom_range(0, 7) == 0);
      flush = 1'($urandom_range(0, 7) == 0);
      #1;
      checks++;
      if (load_use_stall !== 1'(hazard(exp_st, idin)) ||
          pc_write !== !(hazard(exp_st, idin) || stall_ext) || ifid_write !== pc_write) begin
        errors++; $display("FAIL rand_comb[%0d]: got lus=%b pc_write=%b ifid_write=%b", n,
                            load_use_stall, pc_write, ifid_write);
      end
      step();
      checks++;
      if (obs !== exp_st) begin errors++; $display("FAIL rand_regs[%0d]: got %h want %h", n, obs, exp_st); end
`ifdef ID_EX_PERF_CNT_EN
      checks++;
      if (bubble_count !== 32'(model_bubbles)) begin
        errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, bubble_count, model_bubbles);
      end
`endif
    end
    rst = 0; stall_ext = 0; flush = 0;
  endtask

`ifdef ID_EX_PERF_CNT_EN
  task automatic test_counter();
    rst = 1; idin = '0; step(); rst = 0;
    flush = 1;
    repeat (3) step();
    flush = 0;
    idin = rand_id(31); idin.valid = 1; idin.mr = 1; idin.rd = 3;
    step();
    idin = rand_id(31); idin.valid = 1; idin.rs_1 = 3;
    step();
    stall_ext = 1; flush = 1;
    repeat (2) step();
    stall_ext = 0; flush = 0;
    checks++;
    if (bubble_count !== 32'd4) begin
      errors++; $display("FAIL bubble_count: got %0d want 4", bubble_count);
    end
  endtask
`endif

  initial begin
    rst = 1; stall_ext = 0; flush = 0; idin = '0; exp_st = '0; model_bubbles = 0;
    test_reset();
    test_plain_flow();
    test_load_use();
    test_x0_dest();
    test_flush_stall();
    test_random();
`ifdef ID_EX_PERF_CNT_EN
    test_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
